// File: rtl/femto_uart_pkg.sv
// Shared UART definitions: state encoding, frame width and bit-period helpers.
// Used by the receiver now and intended for the future transmitter.
package femto_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int DATA_BITS = 8;
  localparam int MIN_DIV   = 4;

  // Clocks per bit, integer-truncated.
  function automatic int calc_div(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

  function automatic bit div_ok(input int div);
    return div >= MIN_DIV;
  endfunction

endpackage

// File: rtl/femto_sync2.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module femto_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/femto_uart_rx.sv
// UART receiver, 8N1 LSB first, with a one-byte holding register and sticky error flags.
// Define FEMTO_UART_RX_PARITY_EN for 8E1 frames and a parity_err output.
module femto_uart_rx
  import femto_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
`ifdef FEMTO_UART_RX_PARITY_EN
  ,output logic      parity_err
`endif
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (!div_ok(DIV)) begin : g_div_check
    $error("femto_uart_rx: CLK_FREQ_HZ/BAUD must be at least 4");
  end

  logic                 rxs;
  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [2:0]           idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 armed, armed_nxt;
  logic                 deliver, deliver_nxt;
  logic                 frame_set;
`ifdef FEMTO_UART_RX_PARITY_EN
  logic                 par_bit, par_bit_nxt;
  logic                 parity_set;
`endif

  femto_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rxd),
    .q      (rxs)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      armed   <= 1'b0;
      deliver <= 1'b0;
`ifdef FEMTO_UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      armed   <= armed_nxt;
      deliver <= deliver_nxt;
`ifdef FEMTO_UART_RX_PARITY_EN
      par_bit <= par_bit_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    shreg_nxt   = shreg;
    armed_nxt   = armed;
    deliver_nxt = 1'b0;
    frame_set   = 1'b0;
`ifdef FEMTO_UART_RX_PARITY_EN
    par_bit_nxt = par_bit;
    parity_set  = 1'b0;
`endif
    case (state)
      // A start edge only counts once the line has been seen idle-high,
      // so a held-low break cannot retrigger reception.
      IDLE: begin
        cnt_nxt = '0;
        if (rxs) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rxs ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nxt        = '0;
          shreg_nxt[idx] = rxs;
          idx_nxt        = idx + 3'd1;
          if (idx == 3'(DATA_BITS - 1)) begin
`ifdef FEMTO_UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`ifdef FEMTO_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == LAST) begin
          cnt_nxt     = '0;
          par_bit_nxt = rxs;
          state_nxt   = STOP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rxs) begin
`ifdef FEMTO_UART_RX_PARITY_EN
            if (^{shreg, par_bit}) parity_set = 1'b1;
            else                   deliver_nxt = 1'b1;
`else
            deliver_nxt = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
            armed_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read clears first; a same-cycle delivery or error then takes priority.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data       <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef FEMTO_UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (rd) begin
        valid      <= 1'b0;
        overrun    <= 1'b0;
        frame_err  <= 1'b0;
`ifdef FEMTO_UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      if (deliver) begin
        if (!valid || rd) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (frame_set) frame_err <= 1'b1;
`ifdef FEMTO_UART_RX_PARITY_EN
      if (parity_set) parity_err <= 1'b1;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_femto_uart_rx.sv
// Directed bench for femto_uart_rx at DIV=16 (1.6 MHz clock, 100 kbaud).
// Builds with or without FEMTO_UART_RX_PARITY_EN.
module tb_femto_uart_rx;

  localparam int CLK_FREQ_HZ = 1600000;
  localparam int BAUD        = 100000;
  localparam int DIV         = 16;
`ifdef FEMTO_UART_RX_PARITY_EN
  localparam int LAT = 2 + DIV / 2 + 10 * DIV + 2;
`else
  localparam int LAT = 2 + DIV / 2 + 9 * DIV + 2;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       valid, overrun, frame_err, busy;
`ifdef FEMTO_UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  femto_uart_rx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rxd       (rxd),
    .rd        (rd),
    .data      (data),
    .valid     (valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef FEMTO_UART_RX_PARITY_EN
    ,.parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (DIV) @(negedge clk);
  endtask

  // Leaves rxd at the stop-bit level so a low stop can be extended into a break.
  task automatic send_raw(input logic [7:0] b, input logic par, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef FEMTO_UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par !== 1'bx) begin end
`endif
    send_bit(stop_bit);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_raw(b, ^b, stop_bit);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp %h", data, 8'h00); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int lat;
    lat = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        while (lat < 400) begin
          @(negedge clk);
          lat++;
          if (valid === 1'b1) break;
        end
      end
    join
    repeat (2) @(negedge clk);
    checks++; if (lat < LAT - 2 || lat > LAT) begin errors++; $display("FAIL single_latency got %0d exp %0d..%0d", lat, LAT - 2, LAT); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", valid); end
    checks++; if (data !== 8'h55) begin errors++; $display("FAIL single_data got %h exp 55", data); end
    checks++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL single_flags got %b%b exp 00", overrun, frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy); end
    pulse_rd();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_rd_valid got %b exp 0", valid); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", valid); end
    checks++; if (data !== 8'hA3) begin errors++; $display("FAIL b2b_data got %h exp a3", data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b exp 1", overrun); end
    pulse_rd();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_rd_valid got %b exp 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_rd_overrun got %b exp 0", overrun); end
  endtask

  task automatic test_framing();
    logic busy_seen;
    send_frame(8'h12, 1'b0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frm_err got %b exp 1", frame_err); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL frm_valid got %b exp 0", valid); end
    busy_seen = 1'b0;
    repeat (40 * DIV) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL frm_break_busy got %b exp 0", busy_seen); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL frm_break_valid got %b exp 0", valid); end
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    send_frame(8'h34, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (valid !== 1'b1 || data !== 8'h34) begin errors++; $display("FAIL frm_recover got %b/%h exp 1/34", valid, data); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frm_sticky got %b exp 1", frame_err); end
    pulse_rd();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frm_rd_clear got %b exp 0", frame_err); end
  endtask

  task automatic test_glitch();
    logic busy_seen;
    busy_seen = 1'b0;
    rxd = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    rxd = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_started got %b exp 1", busy_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b exp 0", valid); end
    checks++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL glitch_flags got %b%b exp 00", overrun, frame_err); end
  endtask

  task automatic test_reset_mid();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rxd = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rstmid_in_reset got %b%b exp 00", busy, valid); end
    resetn = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    send_frame(8'hC8, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (valid !== 1'b1 || data !== 8'hC8) begin errors++; $display("FAIL rstmid_data got %b/%h exp 1/c8", valid, data); end
    checks++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_flags got %b%b exp 00", overrun, frame_err); end
    pulse_rd();
    repeat (5 * DIV) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_single got %b exp 0", valid); end
  endtask

`ifdef FEMTO_UART_RX_PARITY_EN
  task automatic test_parity();
    send_raw(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (valid !== 1'b1 || data !== 8'h07) begin errors++; $display("FAIL par_good got %b/%h exp 1/07", valid, data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good_err got %b exp 0", parity_err); end
    pulse_rd();
    send_raw(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_err got %b exp 1", parity_err); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL par_bad_valid got %b exp 0", valid); end
    pulse_rd();
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_rd_clear got %b exp 0", parity_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_reset_mid();
`ifdef FEMTO_UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
